phy_ofifo_ctrl: RTL and testbench
=================================

# phy_ofifo_ctrl

Write-side controller for a 7-series PHY output FIFO. Sequences the FIFO's reset after power-up or flush, then shares the FIFO write port between two requesters, the command path (req0) and the data path (req1), using round-robin arbitration. An internal credit counter tracks occupancy so the FIFO never overflows, because the FIFO's FULL flag lags the write clock. The controller sits between the PHY sequencer and the FIFO primitive, on the FIFO's write clock.

## Interface
- DEPTH, 8: FIFO entries; the credit limit.
- DW, 80: write word width (10 lanes x 8 bit).
- RST_CYCLES, 8: cycles `o_fifo_reset` is held high.
- SETTLE_CYCLES, 4: idle cycles after reset release before writes are accepted.
- i_clk  in  1  controller clock; the same clock as the FIFO WRCLK.
- i_nrst  in  1  reset, asynchronous, active-low.
- i_req0_valid  in  1  command requester has a word.
- i_req0_data  in  DW  command word.
- o_req0_ready  out  1  command word accepted this cycle.
- i_req1_valid  in  1  data requester has a word.
- i_req1_data  in  DW  data word.
- o_req1_ready  out  1  data word accepted this cycle.
- i_credit_ret  in  1  one-cycle pulse per entry consumed on the read side, already synchronised to i_clk.
- i_flush  in  1  pulse; drain the FIFO, then re-reset it.
- i_fifo_full  in  1  FIFO FULL flag.
- o_fifo_reset  out  1  drives the FIFO RESET input.
- o_fifo_wren  out  1  drives the FIFO WREN input.
- o_fifo_d  out  DW  drives FIFO D9..D0; D0 occupies [7:0].
- o_level  out  $clog2(DEPTH+1)  current credit count.
- o_busy  out  1  high in every state except RUN.

## Operation
- FSM states: RST_HOLD, SETTLE, RUN, DRAIN.
  - RST_HOLD: `o_fifo_reset`=1; a counter runs RST_CYCLES cycles, then the FSM moves to SETTLE and clears the credit count.
  - SETTLE: counts SETTLE_CYCLES cycles, then moves to RUN.
  - RUN: accepts writes. An `i_flush` pulse moves the FSM to DRAIN.
  - DRAIN: both readies are 0. When credit==0, the FSM moves to RST_HOLD.
- Accept condition: state==RUN && credit<DEPTH && !i_fifo_full. Only then can a ready be high.
- Arbitration:
  - At most one ready per cycle.
  - If only one requester is valid, it is granted.
  - If both are valid, the requester that was not granted last is granted.
  - The last-grant pointer resets to 1, so req0 wins the first contention.
- Readies depend combinationally on valids, state, credit and i_fifo_full. A handshake is valid && ready.
- Credit arithmetic:
  - next = credit + handshake − i_credit_ret.
  - A simultaneous write and return leaves credit unchanged.
  - A return at credit==0 saturates at 0 and sets the error flag (see Configuration).
  - Credit cannot exceed DEPTH by construction.
- `i_flush` is ignored outside RUN. If it coincides with a handshake, the write completes and the flush is taken.
- `i_credit_ret` is honoured in every state except RST_HOLD, where it is dropped.

## Timing
- Reset values (i_nrst low):
  - FSM=RST_HOLD, `o_fifo_reset`=1, `o_fifo_wren`=0, `o_fifo_d`=0.
  - `o_level`=0, `o_busy`=1, both readies 0, pointer=1.
- Latency:
  - The handshake in cycle N produces `o_fifo_wren`=1 with the registered `o_fifo_d` in cycle N+1.
  - `o_fifo_wren` drops in N+1 if there was no handshake in N.
- `o_level` is registered and reflects handshakes and returns of the previous cycle.
- Bring-up: after i_nrst deasserts, `o_fifo_reset` falls after exactly RST_CYCLES clocks. The first ready can rise SETTLE_CYCLES clocks later, 12 cycles with defaults.
- Reset mid-operation: an asynchronous return to the reset values above. Words in flight are discarded.

## Configuration
- PHY_OFIFO_ERR_EN defined: adds output `o_err`.
  - `o_err` is a sticky flag, reset 0.
  - Set on a credit underflow, or when i_fifo_full=1 while credit<DEPTH−1 in RUN, which indicates a lost credit.
  - Cleared only by i_nrst or by entering RST_HOLD.
- Not defined: no `o_err` port and no checking logic; an underflow silently saturates.

## Structure
- Package `phy_ofifo_pkg`:
  - enum `ofifo_state_t` {RST_HOLD, SETTLE, RUN, DRAIN}.
  - localparams for default DEPTH, DW, RST_CYCLES, SETTLE_CYCLES.
  - credit width function.
- Sub-module `ofifo_rr_arb2`: a two-input round-robin arbiter with enable, grant vector and last-grant pointer register.
- Everything else (FSM, counters, output register) stays in `phy_ofifo_ctrl`.

## Test plan
- Bring-up: release i_nrst at t0 → `o_fifo_reset` high for 8 clocks; ready low until clock 12; `o_level`=0.
- Single requester, no returns: req1 valid continuously → exactly 8 handshakes; `o_level`=8; ready stays 0 afterwards; 8 `o_fifo_wren` pulses, each one cycle after its handshake with matching data.
- Contention: both valid, ample credit → grants alternate 0,1,0,1 starting with req0; each data word appears unaltered on `o_fifo_d`.
- Simultaneous write and return at credit 8 → no handshake; at credit 5 with write and return → `o_level` stays 5.
- Flush with credit 3: `i_flush` pulse → readies 0, `o_busy`=1; after 3 returns the FSM enters RST_HOLD (`o_fifo_reset`=1 for 8 clocks), then RUN resumes.
- Error path, with PHY_OFIFO_ERR_EN: return at credit 0 → `o_err`=1 and `o_level` stays 0; assert i_nrst → `o_err`=0. Without the macro: same stimulus, no port, `o_level` stays 0.

Source files
------------

// File: rtl/phy_ofifo_pkg.sv
// phy_ofifo_pkg: shared types and defaults for the PHY output-FIFO write controller.
//   ofifo_state_t  : controller FSM states
//   DEF_*          : default parameter values
//   credit_w()     : width of a counter that holds 0..depth
package phy_ofifo_pkg;

  typedef enum logic [1:0] {
    RST_HOLD = 2'd0,
    SETTLE   = 2'd1,
    RUN      = 2'd2,
    DRAIN    = 2'd3
  } ofifo_state_t;

  localparam int DEF_DEPTH         = 8;
  localparam int DEF_DW            = 80;
  localparam int DEF_RST_CYCLES    = 8;
  localparam int DEF_SETTLE_CYCLES = 4;

  function automatic int credit_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ofifo_rr_arb2.sv
// ofifo_rr_arb2: two-input round-robin arbiter with enable.
//   i_clk, i_nrst : clock, asynchronous active-low reset
//   i_en          : grants allowed this cycle
//   i_req[1:0]    : request vector (bit 0 = command path, bit 1 = data path)
//   o_gnt[1:0]    : one-hot-or-zero grant, combinational
// The last-grant pointer resets to 1 so requester 0 wins the first contention.
module ofifo_rr_arb2 (
  input  logic       i_clk,
  input  logic       i_nrst,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  logic last_q;
  logic last_d;

  always_comb begin
    o_gnt = 2'b00;
    if (i_en) begin
      if (i_req[0] && i_req[1]) begin
        // Contention: favour whoever was not served last.
        o_gnt = last_q ? 2'b01 : 2'b10;
      end else if (i_req[0]) begin
        o_gnt = 2'b01;
      end else if (i_req[1]) begin
        o_gnt = 2'b10;
      end
    end

    last_d = last_q;
    if (o_gnt[0]) begin
      last_d = 1'b0;
    end else if (o_gnt[1]) begin
      last_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/phy_ofifo_ctrl.sv
// phy_ofifo_ctrl: write-side controller for a 7-series PHY output FIFO.
// Sequences the FIFO reset, arbitrates the write port between the command
// path (req0) and the data path (req1), and tracks occupancy with credits
// because the FIFO FULL flag lags the write clock.
//   i_clk, i_nrst         : FIFO write clock, asynchronous active-low reset
//   i_reqN_valid/_data    : requester words;  o_reqN_ready : accepted this cycle
//   i_credit_ret          : one pulse per entry consumed on the read side
//   i_flush               : drain the FIFO then re-reset it (RUN only)
//   i_fifo_full           : FIFO FULL flag
//   o_fifo_reset/_wren/_d : FIFO RESET, WREN, D9..D0 (D0 in [7:0])
//   o_level               : credit count;  o_busy : not in RUN
// Optional macro PHY_OFIFO_ERR_EN adds sticky o_err (credit underflow or a
// FULL flag seen while credit says there is room, i.e. a lost credit).
module phy_ofifo_ctrl
  import phy_ofifo_pkg::*;
#(
  parameter int DEPTH         = DEF_DEPTH,
  parameter int DW            = DEF_DW,
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                         i_clk,
  input  logic                         i_nrst,
  input  logic                         i_req0_valid,
  input  logic [DW-1:0]                i_req0_data,
  output logic                         o_req0_ready,
  input  logic                         i_req1_valid,
  input  logic [DW-1:0]                i_req1_data,
  output logic                         o_req1_ready,
  input  logic                         i_credit_ret,
  input  logic                         i_flush,
  input  logic                         i_fifo_full,
  output logic                         o_fifo_reset,
  output logic                         o_fifo_wren,
  output logic [DW-1:0]                o_fifo_d,
  output logic [credit_w(DEPTH)-1:0]   o_level,
  output logic                         o_busy
`ifdef PHY_OFIFO_ERR_EN
  ,
  output logic                         o_err
`endif
);

  localparam int CW      = credit_w(DEPTH);
  localparam int CNT_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int CNTW    = $clog2(CNT_MAX + 1);

  ofifo_state_t  state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [CW-1:0]   credit_q, credit_d;
  logic            wren_q, wren_d;
  logic [DW-1:0]   data_q, data_d;

  logic [1:0]      gnt;
  logic            accept;
  logic            hs;
  logic            ret;

  // Writes only in RUN, with a free credit, and never against a raised FULL.
  always_comb begin
    accept = (state_q == RUN) && (credit_q < CW'(DEPTH)) && !i_fifo_full;
  end

  ofifo_rr_arb2 u_arb (
    .i_clk  (i_clk),
    .i_nrst (i_nrst),
    .i_en   (accept),
    .i_req  ({i_req1_valid, i_req0_valid}),
    .o_gnt  (gnt)
  );

  always_comb begin
    // A grant is only issued to a valid requester, so grant == handshake.
    hs  = gnt[0] | gnt[1];
    // Returns during RST_HOLD belong to the FIFO being reset and are dropped.
    ret = i_credit_ret && (state_q != RST_HOLD);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNTW'(1);
    case (state_q)
      RST_HOLD: begin
        if (cnt_q == CNTW'(RST_CYCLES - 1)) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        if (cnt_q == CNTW'(SETTLE_CYCLES - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        cnt_d = '0;
        if (i_flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        cnt_d = '0;
        if (credit_q == '0) begin
          state_d = RST_HOLD;
        end
      end
      default: begin
        state_d = RST_HOLD;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    credit_d = credit_q;
    if (state_q == RST_HOLD) begin
      if (state_d == SETTLE) begin
        credit_d = '0;
      end
    end else begin
      case ({hs, ret})
        2'b10:   credit_d = credit_q + CW'(1);
        // A return at zero saturates.
        2'b01:   if (credit_q != '0) credit_d = credit_q - CW'(1);
        default: credit_d = credit_q;
      endcase
    end
  end

  always_comb begin
    wren_d = hs;
    data_d = data_q;
    if (gnt[0]) begin
      data_d = i_req0_data;
    end else if (gnt[1]) begin
      data_d = i_req1_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q  <= RST_HOLD;
      cnt_q    <= '0;
      credit_q <= '0;
      wren_q   <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      credit_q <= credit_d;
      wren_q   <= wren_d;
      data_q   <= data_d;
    end
  end

`ifdef PHY_OFIFO_ERR_EN
  logic err_q, err_d;
  logic underflow;

  always_comb begin
    underflow = ret && !hs && (credit_q == '0);
    err_d     = err_q;
    // FULL while two or more credits remain means a credit went missing.
    if (underflow ||
        ((state_q == RUN) && i_fifo_full && (credit_q < CW'(DEPTH - 1)))) begin
      err_d = 1'b1;
    end
    if ((state_d == RST_HOLD) && (state_q != RST_HOLD)) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign o_err = err_q;
`endif

  assign o_req0_ready = gnt[0];
  assign o_req1_ready = gnt[1];
  assign o_fifo_reset = (state_q == RST_HOLD);
  assign o_fifo_wren  = wren_q;
  assign o_fifo_d     = data_q;
  assign o_level      = credit_q;
  assign o_busy       = (state_q != RUN);

endmodule

// File: tb/tb_phy_ofifo_ctrl.sv
// tb_phy_ofifo_ctrl: directed bench for phy_ofifo_ctrl with a write scoreboard.
// The stimulus process pushes each expected FIFO write (data and the cycle it
// must appear in); a separate monitor pops and compares on every o_fifo_wren.
module tb_phy_ofifo_ctrl;

  localparam int DW = 80;

  logic          i_clk;
  logic          i_nrst;
  logic          i_req0_valid;
  logic [DW-1:0] i_req0_data;
  logic          o_req0_ready;
  logic          i_req1_valid;
  logic [DW-1:0] i_req1_data;
  logic          o_req1_ready;
  logic          i_credit_ret;
  logic          i_flush;
  logic          i_fifo_full;
  logic          o_fifo_reset;
  logic          o_fifo_wren;
  logic [DW-1:0] o_fifo_d;
  logic [3:0]    o_level;
  logic          o_busy;
`ifdef PHY_OFIFO_ERR_EN
  logic          o_err;
`endif

  phy_ofifo_ctrl dut (
    .i_clk        (i_clk),
    .i_nrst       (i_nrst),
    .i_req0_valid (i_req0_valid),
    .i_req0_data  (i_req0_data),
    .o_req0_ready (o_req0_ready),
    .i_req1_valid (i_req1_valid),
    .i_req1_data  (i_req1_data),
    .o_req1_ready (o_req1_ready),
    .i_credit_ret (i_credit_ret),
    .i_flush      (i_flush),
    .i_fifo_full  (i_fifo_full),
    .o_fifo_reset (o_fifo_reset),
    .o_fifo_wren  (o_fifo_wren),
    .o_fifo_d     (o_fifo_d),
    .o_level      (o_level),
    .o_busy       (o_busy)
`ifdef PHY_OFIFO_ERR_EN
    ,
    .o_err        (o_err)
`endif
  );

  typedef struct {
    int            cyc;
    logic [DW-1:0] d;
  } wr_t;

  wr_t sb[$];
  wr_t mon_e;
  int  tests = 0;
  int  fails = 0;
  int  cyc   = 0;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk_b(input string name, input logic act, input logic want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %b, wanted %b (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic chk_w(input string name, input logic [95:0] act, input logic [95:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h, wanted %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic step();
    @(negedge i_clk);
  endtask

  // The handshake of this cycle must show as a write in the next cycle.
  task automatic push(input logic [DW-1:0] d);
    wr_t e;
    e.cyc = cyc + 1;
    e.d   = d;
    sb.push_back(e);
  endtask

  always begin
    @(negedge i_clk);
    #2;
    if (o_fifo_wren === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL wr_unexpected: got write of %0h, wanted no write (cycle %0d)", o_fifo_d, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk_w("wr_data", 96'(o_fifo_d), 96'(mon_e.d));
        chk_w("wr_cycle", 96'(cyc), 96'(mon_e.cyc));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, wanted completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lvl;
    logic [DW-1:0] d0, d1;

    i_nrst = 1'b0; i_req0_valid = 1'b1; i_req1_valid = 1'b1;
    i_req0_data = '0; i_req1_data = '0;
    i_credit_ret = 1'b0; i_flush = 1'b0; i_fifo_full = 1'b0;

    // Reset values, with both requesters pushing.
    step(); #1;
    chk_b("rst_fifo_reset", o_fifo_reset, 1'b1);
    chk_b("rst_wren", o_fifo_wren, 1'b0);
    chk_w("rst_d", 96'(o_fifo_d), 96'(0));
    chk_w("rst_level", 96'(o_level), 96'(0));
    chk_b("rst_busy", o_busy, 1'b1);
    chk_b("rst_ready0", o_req0_ready, 1'b0);
    chk_b("rst_ready1", o_req1_ready, 1'b0);
`ifdef PHY_OFIFO_ERR_EN
    chk_b("rst_err", o_err, 1'b0);
`endif
    step(); step();
    i_nrst = 1'b1;
    i_req0_valid = 1'b0;

    // Bring-up then req1 alone: reset 8 clocks, first ready at 12, 8 writes.
    for (int k = 1; k <= 22; k++) begin
      step();
      i_req1_data = {8'hD1, 8'(k), 64'h0123_4567_89AB_CDEF};
      #1;
      lvl = k - 12;
      if (lvl < 0) lvl = 0;
      if (lvl > 8) lvl = 8;
      chk_b("bu_fifo_reset", o_fifo_reset, (k < 8));
      chk_b("bu_ready1", o_req1_ready, (k >= 12 && k <= 19));
      chk_b("bu_ready0", o_req0_ready, 1'b0);
      chk_w("bu_level", 96'(o_level), 96'(lvl));
      if (k >= 12 && k <= 19) push(i_req1_data);
    end

    // Full credit: write and return together, no handshake.
    step(); i_credit_ret = 1'b1; #1;
    chk_b("full_ready1", o_req1_ready, 1'b0);
    step(); i_req1_valid = 1'b0; #1;
    chk_w("ret_level7", 96'(o_level), 96'(7));
    step(); #1;
    chk_w("ret_level6", 96'(o_level), 96'(6));
    // At credit 5: write and return together.
    step(); i_req1_valid = 1'b1; i_req1_data = {8'hD5, 72'h55_5555_5555_5555_5555}; #1;
    chk_w("wr_ret_level_before", 96'(o_level), 96'(5));
    chk_b("wr_ret_ready1", o_req1_ready, 1'b1);
    push(i_req1_data);
    step(); i_req1_valid = 1'b0; i_credit_ret = 1'b0; #1;
    chk_w("wr_ret_level_after", 96'(o_level), 96'(5));

    for (int i = 0; i < 5; i++) begin
      step(); i_credit_ret = 1'b1; #1;
      chk_w("drain_level", 96'(o_level), 96'(5 - i));
    end

    // Contention: grants alternate starting with req0.
    for (int i = 0; i < 4; i++) begin
      step();
      i_credit_ret = 1'b0;
      i_req0_valid = 1'b1; i_req1_valid = 1'b1;
      d0 = {8'hA0, 8'(i), 64'h1111_2222_3333_4444};
      d1 = {8'hB1, 8'(i), 64'h5555_6666_7777_8888};
      i_req0_data = d0; i_req1_data = d1;
      #1;
      chk_w("arb_level", 96'(o_level), 96'(i));
      chk_b("arb_ready0", o_req0_ready, (i % 2 == 0));
      chk_b("arb_ready1", o_req1_ready, (i % 2 == 1));
      if (i % 2 == 0) push(d0); else push(d1);
    end

    // Flush with credit 3.
    step(); i_req0_valid = 1'b0; i_req1_valid = 1'b0; i_credit_ret = 1'b1; #1;
    chk_w("fl_level4", 96'(o_level), 96'(4));
    step(); i_credit_ret = 1'b0; i_flush = 1'b1; #1;
    chk_w("fl_level3", 96'(o_level), 96'(3));
    chk_b("fl_busy_run", o_busy, 1'b0);
    for (int j = 0; j <= 3; j++) begin
      step();
      i_flush = 1'b0; i_req0_valid = 1'b1; i_req1_valid = 1'b1;
      i_credit_ret = (j < 3);
      #1;
      chk_w("dr_level", 96'(o_level), 96'(3 - j));
      chk_b("dr_busy", o_busy, 1'b1);
      chk_b("dr_ready0", o_req0_ready, 1'b0);
      chk_b("dr_ready1", o_req1_ready, 1'b0);
      chk_b("dr_fifo_reset", o_fifo_reset, 1'b0);
    end
    for (int j = 4; j <= 15; j++) begin
      step();
      i_credit_ret = (j == 5);
      #1;
      chk_b("rh_fifo_reset", o_fifo_reset, (j <= 11));
      chk_b("rh_busy", o_busy, 1'b1);
      chk_b("rh_ready0", o_req0_ready, 1'b0);
      chk_b("rh_ready1", o_req1_ready, 1'b0);
      chk_w("rh_level", 96'(o_level), 96'(0));
    end
    step();
    i_credit_ret = 1'b0;
    i_req0_data = {8'hC0, 72'hCC_CCCC_CCCC_CCCC_CCCC};
    #1;
    chk_b("resume_busy", o_busy, 1'b0);
    chk_b("resume_ready0", o_req0_ready, 1'b1);
    chk_b("resume_ready1", o_req1_ready, 1'b0);
    push(i_req0_data);

    // Underflow: return at credit 0.
    step(); i_req0_valid = 1'b0; i_req1_valid = 1'b0; i_credit_ret = 1'b1; #1;
    chk_w("uf_level1", 96'(o_level), 96'(1));
    step(); #1;
    chk_w("uf_level0", 96'(o_level), 96'(0));
`ifdef PHY_OFIFO_ERR_EN
    chk_b("uf_err_before", o_err, 1'b0);
`endif
    step(); i_credit_ret = 1'b0; i_fifo_full = 1'b1; i_req0_valid = 1'b1; #1;
    chk_w("uf_level_sat", 96'(o_level), 96'(0));
`ifdef PHY_OFIFO_ERR_EN
    chk_b("uf_err_set", o_err, 1'b1);
`endif
    chk_b("fifo_full_ready0", o_req0_ready, 1'b0);

    // Asynchronous reset mid-operation.
    step(); #2;
    i_fifo_full = 1'b0; i_req1_valid = 1'b1;
    i_nrst = 1'b0;
    #1;
    chk_b("ar_fifo_reset", o_fifo_reset, 1'b1);
    chk_b("ar_wren", o_fifo_wren, 1'b0);
    chk_w("ar_d", 96'(o_fifo_d), 96'(0));
    chk_w("ar_level", 96'(o_level), 96'(0));
    chk_b("ar_busy", o_busy, 1'b1);
    chk_b("ar_ready0", o_req0_ready, 1'b0);
    chk_b("ar_ready1", o_req1_ready, 1'b0);
`ifdef PHY_OFIFO_ERR_EN
    chk_b("ar_err", o_err, 1'b0);
`endif
    step(); step();
    chk_w("sb_pending", 96'(sb.size()), 96'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
